// File: rtl/kmeans_pkg.sv
// kmeans_pkg -- shared types and constants for the multi-pass BRAM controller.
//   state_t       : controller FSM states
//   DEF_* / PN_* / RES_* : default address map (PN load window, per-engine result windows)
//   pick_lowest() : index of the lowest set bit of an engine mask (0 when mask is empty)
package kmeans_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_WAIT,
      PICK,
      ENG_WAIT,
      UNLOAD_WAIT,
      DONE
   } state_t;

   localparam int DEF_ADDR_W   = 15;
   localparam int PN_BRAM_BASE = 24576;
   localparam int PN_WORDS     = 8192;
   localparam int RES_BASE     = 0;
   localparam int RES_STRIDE   = 2048;
   localparam int RES_WORDS    = 2048;
   localparam int DEF_TIMEOUT  = 2**20;

   // Scans from the top so the last hit wins, i.e. the lowest set bit.
   function automatic logic [2:0] pick_lowest(input logic [7:0] m);
      logic [2:0] k;
      k = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) k = 3'(i);
      end
      return k;
   endfunction

endpackage

// File: rtl/ctrl_watchdog.sv
// ctrl_watchdog -- saturating cycle counter used to bound the controller's waits.
//   clk, reset : clock, async active-high reset
//   clear      : zero the count (driven on every controller state change)
//   enable     : count while high
//   expired    : count has reached LIMIT (holds until cleared)
module ctrl_watchdog #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != CW'(LIMIT))) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == CW'(LIMIT));

endmodule

// File: rtl/multi_pass_controller.sv
// multi_pass_controller -- sequences one BRAM load, then for each selected engine
// (lowest index first) an engine run followed by an unload of its result window.
//   start/eng_mask/ready/done        : job handshake (mask latched on accepted start)
//   LM_ULM_*                         : loader/unloader command window and completion
//   eng_start/eng_ready              : per-engine one-hot start pulse and completion
//   BRAM_select                      : BRAM owner, 0 = loader, k+1 = engine k
//   err                              : sticky watchdog error
// Build option: define CTRL_WATCHDOG_EN to bound every wait state by TIMEOUT_CYC
// cycles; without it err is tied low and waits are unbounded.
//
// state       | meaning
// IDLE        | ready=1, waiting for start
// LOAD_WAIT   | PN load in progress, waiting for LM_ULM_ready
// PICK        | choose lowest remaining engine, pulse its start
// ENG_WAIT    | engine k owns BRAM, waiting for eng_ready[k]
// UNLOAD_WAIT | unloading engine k results, waiting for LM_ULM_ready
// DONE        | pulse done, return to IDLE
module multi_pass_controller
   import kmeans_pkg::*;
#(
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int NUM_ENG       = 2,
   parameter int LOAD_BASE     = PN_BRAM_BASE,
   parameter int LOAD_WORDS    = PN_WORDS,
   parameter int UNLOAD_BASE   = RES_BASE,
   parameter int UNLOAD_STRIDE = RES_STRIDE,
   parameter int UNLOAD_WORDS  = RES_WORDS,
   parameter int TIMEOUT_CYC   = DEF_TIMEOUT
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [NUM_ENG-1:0]             eng_mask,
   output logic                           ready,
   output logic                           done,
   input  logic                           LM_ULM_ready,
   output logic                           LM_ULM_start,
   output logic [ADDR_W-1:0]              LM_ULM_base_address,
   output logic [ADDR_W-1:0]              LM_ULM_upper_limit,
   output logic                           LM_ULM_load_unload,
   output logic [NUM_ENG-1:0]             eng_start,
   input  logic [NUM_ENG-1:0]             eng_ready,
   output logic [$clog2(NUM_ENG+1)-1:0]   BRAM_select,
   output logic                           err
);

   localparam int SEL_W = $clog2(NUM_ENG + 1);
   localparam int AW1   = ADDR_W + 1;
   localparam logic [ADDR_W:0] LOAD_BASE_W = AW1'(LOAD_BASE);
   localparam logic [ADDR_W:0] LOAD_LIM_W  = AW1'(LOAD_BASE) + AW1'(LOAD_WORDS) - AW1'(1);

   state_t               state, state_n;
   logic                 ready_n, done_n, lm_start_n, lu_n;
   logic [ADDR_W-1:0]    base_n, limit_n;
   logic [NUM_ENG-1:0]   eng_start_n, rem_mask, rem_n, cur_oh, cur_oh_n, pick_oh;
   logic [SEL_W-1:0]     sel_n;
   logic [2:0]           cur_eng, cur_n, pick_k;
   logic [ADDR_W:0]      ul_base_w, ul_lim_w;
   logic                 wd_expired;

   assign pick_k    = pick_lowest(8'(rem_mask));
   assign pick_oh   = NUM_ENG'(1) << pick_k;
   assign ul_base_w = AW1'(UNLOAD_BASE) + AW1'(cur_eng) * AW1'(UNLOAD_STRIDE);
   assign ul_lim_w  = ul_base_w + AW1'(UNLOAD_WORDS) - AW1'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state               <= IDLE;
         ready               <= 1'b1;
         done                <= 1'b0;
         LM_ULM_start        <= 1'b0;
         LM_ULM_load_unload  <= 1'b0;
         LM_ULM_base_address <= '0;
         LM_ULM_upper_limit  <= '0;
         eng_start           <= '0;
         BRAM_select         <= '0;
         rem_mask            <= '0;
         cur_eng             <= '0;
         cur_oh              <= '0;
      end else begin
         state               <= state_n;
         ready               <= ready_n;
         done                <= done_n;
         LM_ULM_start        <= lm_start_n;
         LM_ULM_load_unload  <= lu_n;
         LM_ULM_base_address <= base_n;
         LM_ULM_upper_limit  <= limit_n;
         eng_start           <= eng_start_n;
         BRAM_select         <= sel_n;
         rem_mask            <= rem_n;
         cur_eng             <= cur_n;
         cur_oh              <= cur_oh_n;
      end
   end

   // Completions are qualified with "our start pulse is not high right now" so a
   // response in the same cycle as its own start pulse is not taken.
   always_comb begin
      state_n     = state;
      ready_n     = 1'b0;
      done_n      = 1'b0;
      lm_start_n  = 1'b0;
      lu_n        = LM_ULM_load_unload;
      base_n      = LM_ULM_base_address;
      limit_n     = LM_ULM_upper_limit;
      eng_start_n = '0;
      sel_n       = '0;
      rem_n       = rem_mask;
      cur_n       = cur_eng;
      cur_oh_n    = cur_oh;
      case (state)
         IDLE: begin
            ready_n = 1'b1;
            if (start) begin
               ready_n = 1'b0;
               rem_n   = eng_mask;
               if (eng_mask != '0) begin
                  lm_start_n = 1'b1;
                  lu_n       = 1'b0;
                  base_n     = LOAD_BASE_W[ADDR_W-1:0];
                  limit_n    = LOAD_LIM_W[ADDR_W-1:0];
                  state_n    = LOAD_WAIT;
               end else begin
                  state_n = DONE;
               end
            end
         end
         LOAD_WAIT: begin
            if (wd_expired) state_n = DONE;
            else if (LM_ULM_ready && !LM_ULM_start) state_n = PICK;
         end
         PICK: begin
            cur_n       = pick_k;
            cur_oh_n    = pick_oh;
            eng_start_n = pick_oh;
            sel_n       = SEL_W'({1'b0, pick_k} + 4'd1);
            state_n     = ENG_WAIT;
         end
         ENG_WAIT: begin
            if (wd_expired) begin
               state_n = DONE;
            end else if (((eng_ready & cur_oh) != '0) && (eng_start == '0)) begin
               sel_n      = BRAM_select;
               lm_start_n = 1'b1;
               lu_n       = 1'b1;
               base_n     = ul_base_w[ADDR_W-1:0];
               limit_n    = ul_lim_w[ADDR_W-1:0];
               rem_n      = rem_mask & ~cur_oh;
               state_n    = UNLOAD_WAIT;
            end else begin
               sel_n = BRAM_select;
            end
         end
         UNLOAD_WAIT: begin
            if (wd_expired) begin
               state_n = DONE;
            end else if (LM_ULM_ready && !LM_ULM_start) begin
               state_n = (rem_mask != '0) ? PICK : DONE;
            end else begin
               sel_n = BRAM_select;
            end
         end
         DONE: begin
            done_n  = 1'b1;
            ready_n = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

`ifdef CTRL_WATCHDOG_EN
   logic err_q;

   ctrl_watchdog #(.LIMIT(TIMEOUT_CYC)) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (state_n != state),
      .enable  (1'b1),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if ((state == IDLE) && start) begin
         err_q <= 1'b0;
      end else if (wd_expired &&
                   ((state == LOAD_WAIT) || (state == ENG_WAIT) || (state == UNLOAD_WAIT))) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign wd_expired = 1'b0;
   assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_multi_pass_controller.sv
module tb_multi_pass_controller;

   localparam int ADDR_W        = 15;
   localparam int NUM_ENG       = 2;
   localparam int LOAD_BASE     = 24576;
   localparam int LOAD_WORDS    = 8192;
   localparam int UNLOAD_BASE   = 0;
   localparam int UNLOAD_STRIDE = 2048;
   localparam int UNLOAD_WORDS  = 2048;
   localparam int TIMEOUT_CYC   = 16;
   localparam int SEL_W         = $clog2(NUM_ENG + 1);
   localparam int AW_MOD        = 1 << ADDR_W;

   localparam int EV_XFER = 0;
   localparam int EV_ENG  = 1;
   localparam int EV_DONE = 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic [NUM_ENG-1:0]   eng_mask;
   logic                 ready, done;
   logic                 LM_ULM_ready, LM_ULM_start, LM_ULM_load_unload;
   logic [ADDR_W-1:0]    LM_ULM_base_address, LM_ULM_upper_limit;
   logic [NUM_ENG-1:0]   eng_start, eng_ready;
   logic [SEL_W-1:0]     BRAM_select;
   logic                 err;

   typedef struct {
      int kind;
      int a;
      int b;
      int c;
      int d;
   } ev_t;

   ev_t exp_q[$];
   int  chk_cnt  = 0;
   int  pass_cnt = 0;
   int  lm_wait  = 0;
   int  eng_wait = 0;
   bit  eng_mute = 1'b0;
   logic [31:0]        lm_win;
   logic [NUM_ENG-1:0] eng_oh;

   multi_pass_controller #(
      .ADDR_W(ADDR_W), .NUM_ENG(NUM_ENG), .LOAD_BASE(LOAD_BASE), .LOAD_WORDS(LOAD_WORDS),
      .UNLOAD_BASE(UNLOAD_BASE), .UNLOAD_STRIDE(UNLOAD_STRIDE), .UNLOAD_WORDS(UNLOAD_WORDS),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .eng_mask(eng_mask),
      .ready(ready), .done(done),
      .LM_ULM_ready(LM_ULM_ready), .LM_ULM_start(LM_ULM_start),
      .LM_ULM_base_address(LM_ULM_base_address), .LM_ULM_upper_limit(LM_ULM_upper_limit),
      .LM_ULM_load_unload(LM_ULM_load_unload),
      .eng_start(eng_start), .eng_ready(eng_ready),
      .BRAM_select(BRAM_select), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      chk_cnt++;
      if (act === expv) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
   endtask

   task automatic push_ev(input int kind, input int a, input int b, input int c, input int d);
      ev_t e;
      e.kind = kind; e.a = a; e.b = b; e.c = c; e.d = d;
      exp_q.push_back(e);
   endtask

   // Reference: one load of the PN window, then per selected engine (ascending)
   // an engine run and an unload of that engine's result window, then done.
   task automatic push_job(input logic [NUM_ENG-1:0] m);
      int ub;
      if (m != '0) begin
         push_ev(EV_XFER, 0, LOAD_BASE % AW_MOD, (LOAD_BASE + LOAD_WORDS - 1) % AW_MOD, 0);
         for (int k = 0; k < NUM_ENG; k++) begin
            if (m[k]) begin
               ub = (UNLOAD_BASE + k * UNLOAD_STRIDE) % AW_MOD;
               push_ev(EV_ENG, k, 1, 0, k + 1);
               push_ev(EV_XFER, 1, ub, (ub + UNLOAD_WORDS - 1) % AW_MOD, k + 1);
            end
         end
      end
      push_ev(EV_DONE, 0, 1, 0, 0);
   endtask

   task automatic observe(input ev_t act);
      ev_t e;
      chk("event_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("event_kind", act.kind, e.kind);
         chk("event_lu_eng_err", act.a, e.a);
         chk("event_base_onehot_ready", act.b, e.b);
         chk("event_limit", act.c, e.c);
         chk("event_bram_select", act.d, e.d);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ready"}, ready, 1);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_lm_start"}, LM_ULM_start, 0);
      chk({tag, "_load_unload"}, LM_ULM_load_unload, 0);
      chk({tag, "_base"}, LM_ULM_base_address, 0);
      chk({tag, "_limit"}, LM_ULM_upper_limit, 0);
      chk({tag, "_eng_start"}, eng_start, 0);
      chk({tag, "_bram_select"}, BRAM_select, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   // Monitor plus loader/engine responders, all on the falling edge.
   initial begin
      ev_t ev;
      LM_ULM_ready = 1'b0;
      eng_ready    = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            lm_wait = 0; eng_wait = 0;
            LM_ULM_ready = 1'b0; eng_ready = '0;
         end else begin
            if (LM_ULM_start || (eng_start != '0) || done)
               chk("early_advance", 32'((lm_wait > 0) || (eng_wait > 0)), 0);
            if (LM_ULM_start) begin
               ev.kind = EV_XFER; ev.a = int'(LM_ULM_load_unload);
               ev.b = int'(LM_ULM_base_address); ev.c = int'(LM_ULM_upper_limit);
               ev.d = int'(BRAM_select);
               observe(ev);
            end
            if (eng_start != '0) begin
               ev.kind = EV_ENG; ev.a = 0;
               for (int i = 0; i < NUM_ENG; i++) if (eng_start[i]) ev.a = i;
               ev.b = $countones(eng_start); ev.c = 0; ev.d = int'(BRAM_select);
               observe(ev);
            end
            if (done) begin
               ev.kind = EV_DONE; ev.a = int'(err); ev.b = int'(ready);
               ev.c = 0; ev.d = int'(BRAM_select);
               observe(ev);
            end
            // loader: possibly a stray ready in the pulse cycle, real one 1..6 cycles later
            if (LM_ULM_start) begin
               lm_wait      = $urandom_range(1, 6);
               LM_ULM_ready = 1'($urandom);
               lm_win       = {LM_ULM_load_unload, LM_ULM_base_address, LM_ULM_upper_limit};
            end else if (lm_wait > 0) begin
               chk("window_hold", {LM_ULM_load_unload, LM_ULM_base_address, LM_ULM_upper_limit}, lm_win);
               lm_wait--;
               LM_ULM_ready = (lm_wait == 0);
            end else begin
               LM_ULM_ready = 1'b0;
            end
            // engines: other engines' ready bits toggle randomly as noise
            if ((eng_start != '0) && !eng_mute) begin
               eng_oh    = eng_start;
               eng_wait  = $urandom_range(1, 6);
               eng_ready = NUM_ENG'($urandom);
            end else if (eng_wait > 0) begin
               eng_wait--;
               eng_ready = (NUM_ENG'($urandom) & ~eng_oh) | ((eng_wait == 0) ? eng_oh : '0);
            end else begin
               eng_ready = '0;
            end
         end
      end
   end

   task automatic drive_job(input logic [NUM_ENG-1:0] m, input bit wd);
      start    = 1'b1;
      eng_mask = m;
      if (wd) begin
         push_ev(EV_XFER, 0, LOAD_BASE % AW_MOD, (LOAD_BASE + LOAD_WORDS - 1) % AW_MOD, 0);
         push_ev(EV_ENG, 0, 1, 0, 1);
         push_ev(EV_DONE, 1, 1, 0, 0);
      end else begin
         push_job(m);
      end
      @(negedge clk);
      chk("ready_drop", ready, 0);
      chk("err_cleared_on_start", err, 0);
      if (m == '0) begin
         start = 1'b0;
         chk("zero_mask_done_not_yet", done, 0);
         @(negedge clk);
         chk("zero_mask_done_latency", done, 1);
      end else begin
         start    = 1'($urandom);
         eng_mask = NUM_ENG'($urandom);
      end
   endtask

   task automatic issue_job(input logic [NUM_ENG-1:0] m, input bit wd);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (ready || n > 1000) break;
         start    = 1'($urandom);
         eng_mask = NUM_ENG'($urandom);
         n++;
      end
      if (!ready) chk("ready_timeout", ready, 1);
      else drive_job(m, wd);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      start = 1'b0;
      while (!(ready && exp_q.size() == 0) && n < 2000) begin
         @(negedge clk);
         start = 1'b0;
         n++;
      end
      chk("idle_reached", 32'(ready && exp_q.size() == 0), 1);
   endtask

   initial begin
      int n;
      reset    = 1'b1;
      start    = 1'b0;
      eng_mask = '0;
      repeat (2) @(negedge clk);
      check_reset_vals("por");
      #2 reset = 1'b0;
      drive_job(2'b11, 1'b0);
      issue_job(2'b10, 1'b0);
      issue_job(2'b00, 1'b0);
      issue_job(2'b01, 1'b0);
      for (int j = 0; j < 20; j++) issue_job(NUM_ENG'($urandom), 1'b0);

      // asynchronous reset in the middle of an engine run
      issue_job(2'b11, 1'b0);
      n = 0;
      while (eng_wait == 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("reached_eng_wait", 32'(eng_wait > 0), 1);
      #3 reset = 1'b1;
      #1 check_reset_vals("mid_job");
      exp_q.delete();
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      issue_job(2'b11, 1'b0);
      wait_idle();

`ifdef CTRL_WATCHDOG_EN
      eng_mute = 1'b1;
      issue_job(2'b01, 1'b1);
      wait_idle();
      eng_mute = 1'b0;
      chk("err_sticky_after_timeout", err, 1);
      issue_job(2'b11, 1'b0);
`endif
      for (int j = 0; j < 5; j++) issue_job(NUM_ENG'($urandom), 1'b0);
      wait_idle();
      chk("queue_drained", exp_q.size(), 0);
      chk("final_ready", ready, 1);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
      $fatal(1, "bench time limit expired");
   end

endmodule

// File: doc/multi_pass_controller.md
MULTI_PASS_CONTROLLER -- requirements
Module: multi_pass_controller

Interface
REQ-001 Parameter ADDR_W, default 15, SHALL set the BRAM address width.
REQ-002 Parameter NUM_ENG, default 2, range 1..8, SHALL set the number of processing engines (histogram, k-means, ...).
REQ-003 Parameter LOAD_BASE, default 24576, SHALL set the PN load base address.
REQ-004 Parameter LOAD_WORDS, default 8192, SHALL set the number of words loaded.
REQ-005 Parameters UNLOAD_BASE (default 0), UNLOAD_STRIDE (default 2048) and UNLOAD_WORDS (default 2048) SHALL set the per-engine result regions.
REQ-006 Parameter TIMEOUT_CYC, default 2**20, SHALL set the watchdog limit.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 start  in  1  request a job; sampled only when ready=1.
REQ-010 eng_mask  in  NUM_ENG  engines to run; latched with start.
REQ-011 ready  out  1  registered; 1 = idle, accepting start.
REQ-012 done  out  1  one-cycle pulse at job end.
REQ-013 LM_ULM_ready  in  1  loader/unloader finished.
REQ-014 LM_ULM_start  out  1  one-cycle pulse.
REQ-015 LM_ULM_base_address / LM_ULM_upper_limit  out  ADDR_W each  transfer window, held stable from pulse until LM_ULM_ready.
REQ-016 LM_ULM_load_unload  out  1  0 = load, 1 = unload.
REQ-017 eng_start  out  NUM_ENG  one-hot, one-cycle pulse.
REQ-018 eng_ready  in  NUM_ENG  per-engine completion.
REQ-019 BRAM_select  out  $clog2(NUM_ENG+1)  0 = loader owns BRAM; k+1 = engine k owns BRAM.
REQ-020 err  out  1  sticky watchdog error (macro-gated).

Function
REQ-021 States SHALL be IDLE, LOAD_WAIT, PICK, ENG_WAIT, UNLOAD_WAIT, DONE.
REQ-022 IDLE, start=1, mask!=0: latch the mask, pulse LM_ULM_start with load_unload=0, base=LOAD_BASE, limit=LOAD_BASE+LOAD_WORDS-1, deassert ready next cycle, then go to LOAD_WAIT.
REQ-023 IDLE, start=1, mask==0: go to DONE with no load; done pulses the next cycle.
REQ-024 LOAD_WAIT on LM_ULM_ready SHALL go to PICK.
REQ-025 PICK SHALL select the lowest set bit k of the remaining mask, pulse eng_start[k], set BRAM_select=k+1, and go to ENG_WAIT; it takes exactly one cycle.
REQ-026 ENG_WAIT SHALL hold BRAM_select=k+1.
REQ-027 ENG_WAIT on eng_ready[k] SHALL:
- pulse LM_ULM_start with load_unload=1;
- set base=UNLOAD_BASE+k*UNLOAD_STRIDE and limit=base+UNLOAD_WORDS-1;
- clear bit k of the remaining mask;
- go to UNLOAD_WAIT.
REQ-028 eng_ready bits other than k SHALL be ignored.
REQ-029 UNLOAD_WAIT SHALL hold load_unload=1 and BRAM_select=k+1; on LM_ULM_ready it goes to PICK if the remaining mask is nonzero, else to DONE.
REQ-030 DONE SHALL pulse done for one cycle, set ready=1 and return to IDLE.
REQ-031 Address arithmetic SHALL be computed at ADDR_W+1 bits and truncated to ADDR_W (wrap-around permitted).
REQ-032 start while ready=0 SHALL be ignored.
REQ-033 LM_ULM_ready or eng_ready arriving in the same cycle as the corresponding start pulse SHALL be ignored; only later cycles count.

Reset
REQ-034 Asserting reset, including mid-job, SHALL immediately force:
- state=IDLE, ready=1, err=0;
- all pulses, load_unload and BRAM_select to 0;
- base, limit and the latched mask to 0.
REQ-035 The first start is accepted on the first rising edge after reset deasserts.

Configuration
REQ-036 With CTRL_WATCHDOG_EN defined, a counter SHALL clear on every state change and saturate at TIMEOUT_CYC. On reaching TIMEOUT_CYC in LOAD_WAIT, ENG_WAIT or UNLOAD_WAIT, the block sets err=1 and enters DONE. err clears only on reset or on the next accepted start.
REQ-037 Without CTRL_WATCHDOG_EN, the counter SHALL be absent, err tied to 0, and the waits unbounded.

Structure
REQ-038 The state enum, the default parameter constants (address width, PN_BRAM_BASE, strides) and a priority-pick function SHALL live in kmeans_pkg.
REQ-039 The watchdog SHALL be a sub-module ctrl_watchdog (inputs clear/enable, output expired), instantiated only under CTRL_WATCHDOG_EN.

Verification
REQ-040 Case 1, default params: start with mask=2'b11, ready responses after 5 cycles. Expected: load 24576..32767, then eng0, unload 0..2047, then eng1, unload 2048..4095, done pulse, ready=1.
REQ-041 Case 2: mask=2'b10. Expected: eng_start never pulses bit 0; the single unload window is 2048..4095; BRAM_select sequence 0,2,0.
REQ-042 Case 3: mask=0. Expected: done pulses two cycles after start; LM_ULM_start never pulses.
REQ-043 Case 4: start asserted continuously during a job. Expected: no second job until ready=1, then exactly one new job.
REQ-044 Case 5: reset asserted mid ENG_WAIT. Expected: outputs at reset values asynchronously; a subsequent job completes normally.
REQ-045 Case 6: CTRL_WATCHDOG_EN with TIMEOUT_CYC=16, eng_ready never asserted. Expected: err=1 and done pulse after 16 cycles in ENG_WAIT; err clears on the next start.
